// File: rtl/valu_issue_ctrl.sv
// Issue-side sequencer for the vector ALU: accepts one instruction, starts the VALU,
// waits for completion (or times out) and offers the captured results to writeback.
module valu_issue_ctrl #(
    parameter int LANES          = 16,
    parameter int WFID_W         = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [WFID_W-1:0]     issue_wfid,
    input  logic [31:0]           issue_opcode,
    input  logic [LANES*32-1:0]   issue_src1_data,
    input  logic [LANES*32-1:0]   issue_src2_data,
    input  logic [LANES*32-1:0]   issue_src3_data,
    input  logic [LANES-1:0]      issue_vcc_value,
    input  logic [LANES-1:0]      issue_exec_value,

    output logic [LANES*32-1:0]   alu_source1_data,
    output logic [LANES*32-1:0]   alu_source2_data,
    output logic [LANES*32-1:0]   alu_source3_data,
    output logic [LANES-1:0]      alu_source_vcc_value,
    output logic [LANES-1:0]      alu_source_exec_value,
    output logic [31:0]           alu_control,
    output logic                  alu_start,

    input  logic [LANES*32-1:0]   alu_vgpr_dest_data,
    input  logic [LANES-1:0]      alu_sgpr_dest_data,
    input  logic [LANES-1:0]      alu_dest_vcc_value,
    input  logic [LANES-1:0]      alu_dest_exec_value,
    input  logic                  valu_done,

    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [WFID_W-1:0]     wb_wfid,
    output logic [LANES*32-1:0]   wb_vgpr_data,
    output logic [LANES-1:0]      wb_sgpr_data,
    output logic [LANES-1:0]      wb_vcc_value,
    output logic [LANES-1:0]      wb_exec_value,
    output logic                  wb_error
);

    localparam int DW    = LANES * 32;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              accept;
    logic              capture_done;
    logic              timed_out;
    logic [CNT_W-1:0]  busy_cnt_q;

    logic [WFID_W-1:0] wfid_q;
    logic [31:0]       opcode_q;
    logic [DW-1:0]     src1_q, src2_q, src3_q;
    logic [LANES-1:0]  vcc_q, exec_q;

    logic [DW-1:0]     res_vgpr_q;
    logic [LANES-1:0]  res_sgpr_q, res_vcc_q, res_exec_q;
    logic              res_error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // done is only honoured in BUSY and takes priority over an expiring timeout
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        capture_done = 1'b0;
        timed_out    = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    accept  = 1'b1;
                    state_d = (issue_opcode == 32'd0) ? WB : START;
                end
            end
            START: state_d = BUSY;
            BUSY: begin
                if (valu_done) begin
                    capture_done = 1'b1;
                    state_d      = WB;
                end else if (busy_cnt_q == CNT_LAST) begin
                    timed_out = 1'b1;
                    state_d   = WB;
                end
            end
            WB: begin
                if (wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wfid_q   <= '0;
            opcode_q <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            src3_q   <= '0;
            vcc_q    <= '0;
            exec_q   <= '0;
        end else if (accept) begin
            wfid_q   <= issue_wfid;
            opcode_q <= issue_opcode;
            src1_q   <= issue_src1_data;
            src2_q   <= issue_src2_data;
            src3_q   <= issue_src3_data;
            vcc_q    <= issue_vcc_value;
            exec_q   <= issue_exec_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt_q <= '0;
        end else if (state_q == START) begin
            busy_cnt_q <= '0;
        end else if (state_q == BUSY && !valu_done) begin
            busy_cnt_q <= busy_cnt_q + 1'b1;
        end
    end

    // NOPs and timeouts both write back zero data with the original exec mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_vgpr_q  <= '0;
            res_sgpr_q  <= '0;
            res_vcc_q   <= '0;
            res_exec_q  <= '0;
            res_error_q <= 1'b0;
        end else if (accept && issue_opcode == 32'd0) begin
            res_vgpr_q  <= '0;
            res_sgpr_q  <= '0;
            res_vcc_q   <= '0;
            res_exec_q  <= issue_exec_value;
            res_error_q <= 1'b0;
        end else if (capture_done) begin
            res_vgpr_q  <= alu_vgpr_dest_data;
            res_sgpr_q  <= alu_sgpr_dest_data;
            res_vcc_q   <= alu_dest_vcc_value;
            res_exec_q  <= alu_dest_exec_value;
            res_error_q <= 1'b0;
        end else if (timed_out) begin
            res_vgpr_q  <= '0;
            res_sgpr_q  <= '0;
            res_vcc_q   <= '0;
            res_exec_q  <= exec_q;
            res_error_q <= 1'b1;
        end
    end

    // Zero control outside START/BUSY forces the VALU to drop done between ops
    assign issue_ready           = (state_q == IDLE);
    assign alu_start             = (state_q == START);
    assign alu_control           = (state_q == START || state_q == BUSY) ? opcode_q : 32'd0;
    assign alu_source1_data      = src1_q;
    assign alu_source2_data      = src2_q;
    assign alu_source3_data      = src3_q;
    assign alu_source_vcc_value  = vcc_q;
    assign alu_source_exec_value = exec_q;

    assign wb_valid      = (state_q == WB);
    assign wb_wfid       = wfid_q;
    assign wb_vgpr_data  = res_vgpr_q;
    assign wb_sgpr_data  = res_sgpr_q;
    assign wb_vcc_value  = res_vcc_q;
    assign wb_exec_value = res_exec_q;
    assign wb_error      = res_error_q;

endmodule

// File: tb/tb_valu_issue_ctrl.sv
// Scoreboard bench for valu_issue_ctrl: a small VALU model answers after a programmable
// delay, and every writeback is checked against expectations queued at issue time.
module tb_valu_issue_ctrl;

    localparam int LANES   = 16;
    localparam int WFID_W  = 6;
    localparam int TIMEOUT = 8;
    localparam int DW      = LANES * 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic              issue_ready;
    logic [WFID_W-1:0] issue_wfid;
    logic [31:0]       issue_opcode;
    logic [DW-1:0]     issue_src1_data, issue_src2_data, issue_src3_data;
    logic [LANES-1:0]  issue_vcc_value, issue_exec_value;
    logic [DW-1:0]     alu_source1_data, alu_source2_data, alu_source3_data;
    logic [LANES-1:0]  alu_source_vcc_value, alu_source_exec_value;
    logic [31:0]       alu_control;
    logic              alu_start;
    logic [DW-1:0]     alu_vgpr_dest_data;
    logic [LANES-1:0]  alu_sgpr_dest_data, alu_dest_vcc_value, alu_dest_exec_value;
    logic              valu_done;
    logic              wb_valid;
    logic              wb_ready;
    logic [WFID_W-1:0] wb_wfid;
    logic [DW-1:0]     wb_vgpr_data;
    logic [LANES-1:0]  wb_sgpr_data, wb_vcc_value, wb_exec_value;
    logic              wb_error;

    valu_issue_ctrl #(.LANES(LANES), .WFID_W(WFID_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_wfid(issue_wfid),
        .issue_opcode(issue_opcode), .issue_src1_data(issue_src1_data),
        .issue_src2_data(issue_src2_data), .issue_src3_data(issue_src3_data),
        .issue_vcc_value(issue_vcc_value), .issue_exec_value(issue_exec_value),
        .alu_source1_data(alu_source1_data), .alu_source2_data(alu_source2_data),
        .alu_source3_data(alu_source3_data), .alu_source_vcc_value(alu_source_vcc_value),
        .alu_source_exec_value(alu_source_exec_value), .alu_control(alu_control),
        .alu_start(alu_start), .alu_vgpr_dest_data(alu_vgpr_dest_data),
        .alu_sgpr_dest_data(alu_sgpr_dest_data), .alu_dest_vcc_value(alu_dest_vcc_value),
        .alu_dest_exec_value(alu_dest_exec_value), .valu_done(valu_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wfid(wb_wfid),
        .wb_vgpr_data(wb_vgpr_data), .wb_sgpr_data(wb_sgpr_data),
        .wb_vcc_value(wb_vcc_value), .wb_exec_value(wb_exec_value), .wb_error(wb_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] model_vgpr(input logic [DW-1:0] a, b, c);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*32 +: 32] = (a[i*32 +: 32] + b[i*32 +: 32]) ^ c[i*32 +: 32];
        return r;
    endfunction

    // VALU model: done once 'done_delay' cycles have passed since start, or at once with exec==0
    logic [7:0] done_delay;
    logic [7:0] valu_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst)                  valu_cnt <= 8'd0;
        else if (alu_start)       valu_cnt <= 8'd0;
        else if (valu_cnt != 8'hFF) valu_cnt <= valu_cnt + 8'd1;
    end
    assign valu_done           = (alu_control != 32'd0) &&
                                 (alu_source_exec_value == '0 || valu_cnt == done_delay);
    assign alu_vgpr_dest_data  = model_vgpr(alu_source1_data, alu_source2_data, alu_source3_data);
    assign alu_sgpr_dest_data  = alu_source_vcc_value ^ alu_source_exec_value;
    assign alu_dest_vcc_value  = ~alu_source_vcc_value;
    assign alu_dest_exec_value = alu_source_exec_value;

    typedef struct {
        logic [WFID_W-1:0] wfid;
        logic [DW-1:0]     vgpr;
        logic [LANES-1:0]  sgpr;
        logic [LANES-1:0]  vcc;
        logic [LANES-1:0]  exec;
        logic              err;
        int                acc;
        int                lat;
    } exp_t;

    exp_t sb[$];

    int         start_cnt = 0;
    int         last_start_cyc = 0;
    logic [31:0] last_ctl = '0;
    int         hs_cyc = 0;
    int         last_acc = 0;
    bit         wb_seen = 0;

    // Writeback monitor: latency on the first wb_valid cycle, data every cycle, pop on handshake
    always @(negedge clk) begin
        if (rst) begin
            wb_seen = 0;
        end else begin
            if (alu_start) begin
                start_cnt++;
                last_start_cyc = cyc;
                last_ctl = alu_control;
            end
            if (wb_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_wb", DW'(wb_valid), DW'(0));
                end else begin
                    if (!wb_seen) begin
                        checkOutput("wb_latency", DW'(cyc - sb[0].acc), DW'(sb[0].lat));
                        wb_seen = 1;
                    end
                    checkOutput("wb_vgpr", wb_vgpr_data, sb[0].vgpr);
                    checkOutput("ready_in_wb", DW'(issue_ready), DW'(0));
                    if (wb_ready) begin
                        checkOutput("wb_wfid", DW'(wb_wfid), DW'(sb[0].wfid));
                        checkOutput("wb_sgpr", DW'(wb_sgpr_data), DW'(sb[0].sgpr));
                        checkOutput("wb_vcc", DW'(wb_vcc_value), DW'(sb[0].vcc));
                        checkOutput("wb_exec", DW'(wb_exec_value), DW'(sb[0].exec));
                        checkOutput("wb_error", DW'(wb_error), DW'(sb[0].err));
                        hs_cyc = cyc;
                        void'(sb.pop_front());
                        wb_seen = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WFID_W-1:0] wfid, input logic [31:0] op,
                                 input logic [DW-1:0] s1, s2, s3,
                                 input logic [LANES-1:0] vcc, exec,
                                 input int delay, input bit track);
        exp_t e;
        int   n;
        tick();
        issue_valid      = 1'b1;
        issue_wfid       = wfid;
        issue_opcode     = op;
        issue_src1_data  = s1;
        issue_src2_data  = s2;
        issue_src3_data  = s3;
        issue_vcc_value  = vcc;
        issue_exec_value = exec;
        n = 0;
        while (!issue_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) checkOutput("issue_wait_timeout", DW'(issue_ready), DW'(1));
        last_acc   = cyc;
        done_delay = (delay > 255) ? 8'hFF : 8'(delay);
        e.wfid = wfid;
        e.acc  = cyc;
        e.err  = 1'b0;
        e.exec = exec;
        if (op == 32'd0) begin
            e.vgpr = '0; e.sgpr = '0; e.vcc = '0; e.lat = 1;
        end else if (exec == '0 || delay <= TIMEOUT - 1) begin
            e.vgpr = model_vgpr(s1, s2, s3);
            e.sgpr = vcc ^ exec;
            e.vcc  = ~vcc;
            e.lat  = (exec == '0) ? 3 : delay + 3;
        end else begin
            e.vgpr = '0; e.sgpr = '0; e.vcc = '0; e.err = 1'b1; e.lat = TIMEOUT + 2;
        end
        if (track) sb.push_back(e);
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !issue_ready) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) checkOutput("drain_timeout", DW'(sb.size()), DW'(0));
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DW-1:0] s1, s2, s3;
        int s0, acc_a, acc_b;

        rst = 1'b1;
        issue_valid = 1'b0; issue_wfid = '0; issue_opcode = '0;
        issue_src1_data = '0; issue_src2_data = '0; issue_src3_data = '0;
        issue_vcc_value = '0; issue_exec_value = '0;
        wb_ready = 1'b1; done_delay = 8'd0;
        repeat (3) tick();
        checkOutput("rst_wb_valid", DW'(wb_valid), DW'(0));
        checkOutput("rst_alu_start", DW'(alu_start), DW'(0));
        checkOutput("rst_alu_control", DW'(alu_control), DW'(0));
        rst = 1'b0;
        tick();
        checkOutput("rst_issue_ready", DW'(issue_ready), DW'(1));
        checkOutput("rst_wb_vgpr", wb_vgpr_data, DW'(0));
        checkOutput("rst_wb_error", DW'(wb_error), DW'(0));

        // basic op: src1 lane i = i, done 3 cycles into BUSY
        for (int i = 0; i < LANES; i++) s1[i*32 +: 32] = i;
        s2 = rand_data(); s3 = rand_data();
        s0 = start_cnt;
        applyStimulus(6'h15, 32'h0000_0101, s1, s2, s3, 16'h5A5A, 16'hFFFF, 3, 1);
        acc_a = last_acc;
        drain();
        checkOutput("basic_start_count", DW'(start_cnt - s0), DW'(1));
        checkOutput("basic_start_cycle", DW'(last_start_cyc - acc_a), DW'(1));
        checkOutput("basic_start_ctl", DW'(last_ctl), DW'(32'h0000_0101));

        // NOP never starts the VALU
        s0 = start_cnt;
        applyStimulus(6'h2A, 32'd0, rand_data(), rand_data(), rand_data(), 16'hFFFF, 16'h00F0, 0, 1);
        drain();
        checkOutput("nop_no_start", DW'(start_cnt - s0), DW'(0));

        // zero exec completes on the first BUSY cycle
        applyStimulus(6'h03, 32'h22, rand_data(), rand_data(), rand_data(), 16'h1234, 16'h0000, 200, 1);
        drain();

        // backpressure with a second instruction waiting
        wb_ready = 1'b0;
        applyStimulus(6'h07, 32'h77, rand_data(), rand_data(), rand_data(), 16'h00FF, 16'hF0F0, 2, 1);
        fork
            begin
                applyStimulus(6'h08, 32'h88, rand_data(), rand_data(), rand_data(), 16'hAAAA, 16'h0FF0, 1, 1);
                acc_b = last_acc;
            end
            begin
                int n = 0;
                while (!wb_valid && n < 50) begin tick(); n++; end
                if (n >= 50) checkOutput("bp_wb_wait", DW'(wb_valid), DW'(1));
                for (int k = 0; k < 10; k++) begin
                    tick();
                    checkOutput("bp_issue_ready", DW'(issue_ready), DW'(0));
                    checkOutput("bp_wb_valid", DW'(wb_valid), DW'(1));
                end
                wb_ready = 1'b1;
            end
        join
        checkOutput("bp_second_accept", DW'(acc_b), DW'(hs_cyc + 1));
        drain();

        // timeout, then a clean op, then done on the last counted cycle (done wins)
        applyStimulus(6'h10, 32'h99, rand_data(), rand_data(), rand_data(), 16'h0F0F, 16'h8001, 255, 1);
        applyStimulus(6'h11, 32'h9A, rand_data(), rand_data(), rand_data(), 16'h0F0F, 16'h8001, 1, 1);
        applyStimulus(6'h12, 32'h9B, rand_data(), rand_data(), rand_data(), 16'h3C3C, 16'hFFFF, TIMEOUT - 1, 1);
        applyStimulus(6'h13, 32'h9C, rand_data(), rand_data(), rand_data(), 16'h3C3C, 16'h0001, 0, 1);
        drain();

        // asynchronous reset in the middle of BUSY abandons the op
        s1 = rand_data();
        applyStimulus(6'h20, 32'h33, s1, rand_data(), rand_data(), 16'h1111, 16'hFFFF, 255, 0);
        tick(); tick();
        checkOutput("busy_ctl_held", DW'(alu_control), DW'(32'h33));
        checkOutput("busy_src1_held", alu_source1_data, s1);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_wb_valid", DW'(wb_valid), DW'(0));
        checkOutput("arst_alu_start", DW'(alu_start), DW'(0));
        checkOutput("arst_alu_control", DW'(alu_control), DW'(0));
        tick(); tick();
        rst = 1'b0;
        tick();
        checkOutput("arst_issue_ready", DW'(issue_ready), DW'(1));
        repeat (15) tick();

        // mixed traffic
        for (int i = 0; i < 6; i++) begin
            logic [31:0]      op;
            logic [LANES-1:0] ex;
            op = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom | 32'h1);
            ex = ($urandom_range(0, 4) == 0) ? '0 : LANES'($urandom);
            applyStimulus(WFID_W'(i + 40), op, rand_data(), rand_data(), rand_data(),
                          LANES'($urandom), ex, $urandom_range(0, 10), 1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
